mag_cmp_pipe: RTL
=================

MAG_CMP_PIPE -- requirements
Module: mag_cmp_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits.
REQ-002 SHALL have parameter SLICE, default 4, bits compared per pipeline stage; WIDTH SHALL be an integer multiple of SLICE.
REQ-003 SHALL derive NSTAGES = WIDTH/SLICE as a localparam.
REQ-004 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, upstream offers operands a/b.
REQ-007 SHALL have port in_ready, output, 1, block accepts operands this cycle.
REQ-008 SHALL have port a, input, WIDTH, first operand.
REQ-009 SHALL have port b, input, WIDTH, second operand.
REQ-010 SHALL have port out_valid, output, 1, result flags valid.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-012 SHALL have ports gt, eq, lt, output, 1 each, result a>b, a==b, a<b.

Function
REQ-013 SHALL accept a transfer when in_valid & in_ready; deliver when out_valid & out_ready.
REQ-014 SHALL compare slices MSB-first: stage k (0..NSTAGES-1) compares bits [WIDTH-1-k*SLICE -: SLICE].
REQ-015 Each stage SHALL carry decided flags gt_d/lt_d; once either is set, later slices SHALL NOT change them.
REQ-016 Final stage SHALL produce exactly one of gt/eq/lt high when out_valid=1; eq = ~gt_d & ~lt_d after the last slice.
REQ-017 Latency SHALL be NSTAGES cycles from accept to out_valid with no stall; throughput one result per cycle.
REQ-018 Stage i SHALL load when its register is empty or stage i+1 loads (last stage: out_ready); in_ready = stage-0 load condition.
REQ-019 With out_ready low, the pipeline SHALL fill and then hold; gt/eq/lt/out_valid SHALL stay stable until accepted.
REQ-020 SHALL hold NSTAGES transactions maximum; no loss, duplication or reordering under any valid/ready pattern.
REQ-021 Simultaneous accept at input and delivery at output on a full pipeline SHALL be allowed in the same cycle.
REQ-022 Stages SHALL only carry the operand bits not yet compared.
REQ-023 gt/eq/lt SHALL be 0 whenever out_valid=0.

Reset
REQ-024 reset SHALL asynchronously clear all stage valid bits and gt_d/lt_d; out_valid, gt, eq, lt SHALL be 0 during and after reset.
REQ-025 In-flight transactions SHALL be discarded on reset; in_ready SHALL be 1 on the first cycle after reset deasserts.
REQ-026 Operand data registers need no reset.

Configuration
REQ-027 Macro MAG_CMP_SIGNED_EN defined: operands two's complement; stage 0 SHALL invert the MSB of a and b before comparing.
REQ-028 Macro MAG_CMP_SIGNED_EN undefined: operands unsigned; no inversion; ports and latency identical either way.

Structure
REQ-029 Package mag_cmp_pkg SHALL hold the result encoding constants (GT/EQ/LT one-hot) and the stage-state field widths.
REQ-030 Sub-module mag_cmp_slice SHALL be combinational: inputs SLICE-bit a/b slice plus gt_in/lt_in, outputs gt_out/lt_out; one instance per stage.
REQ-031 Elaboration SHALL fail if WIDTH mod SLICE != 0 or SLICE < 1.

Verification (WIDTH=16, SLICE=4 unless stated)
REQ-032 a=0x1234, b=0x1233, out_ready=1 -> out_valid 4 cycles after accept, gt=1, eq=0, lt=0.
REQ-033 a=b=0xBEEF -> eq=1 only; a=0x0000, b=0xFFFF -> lt=1 only.
REQ-034 a=0x8000, b=0x7FFF -> gt=1 unsigned; lt=1 with MAG_CMP_SIGNED_EN.
REQ-035 Stream 6 back-to-back pairs, out_ready low 5 cycles -> in_ready drops after 4 accepts, all 6 results in order, outputs stable while stalled.
REQ-036 reset pulse with 3 in flight -> out_valid=0 immediately, no stale results emitted, in_ready=1 next cycle.
REQ-037 WIDTH=8, SLICE=8: a=0x05, b=0x09 -> lt=1 after 1 cycle, one result per cycle sustained.

Source files
------------

// File: rtl/mag_cmp_pkg.sv
// Shared definitions for the pipelined magnitude comparator: result encoding,
// per-stage decision flags and the operand-width helper used to size each stage.
package mag_cmp_pkg;

  localparam int RES_W = 3;

  // Result order is {gt, eq, lt}
  localparam logic [RES_W-1:0] RES_GT = 3'b100;
  localparam logic [RES_W-1:0] RES_EQ = 3'b010;
  localparam logic [RES_W-1:0] RES_LT = 3'b001;

  typedef struct packed {
    logic gt_d;
    logic lt_d;
  } flags_t;

  localparam int FLAG_W = $bits(flags_t);

  // Operand bits still to be compared once stage `stage` has consumed its slice.
  function automatic int rem_bits(input int width, input int slice, input int stage);
    return width - (stage + 1) * slice;
  endfunction

endpackage

// File: rtl/mag_cmp_slice.sv
// Combinational compare of one operand slice; an earlier decision always wins
// over this slice.
module mag_cmp_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a_sl,
  input  logic [SLICE-1:0] b_sl,
  input  logic             gt_in,
  input  logic             lt_in,
  output logic             gt_out,
  output logic             lt_out
);

  always_comb begin
    gt_out = gt_in;
    lt_out = lt_in;
    if (!gt_in && !lt_in) begin
      gt_out = (a_sl > b_sl);
      lt_out = (a_sl < b_sl);
    end
  end

endmodule

// File: rtl/mag_cmp_pipe.sv
// Pipelined MSB-first magnitude comparator with valid/ready flow control.
// Define MAG_CMP_SIGNED_EN to compare the operands as two's complement.
module mag_cmp_pipe
  import mag_cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int NSTAGES = (SLICE > 0) ? (WIDTH / SLICE) : 1;

  if (SLICE < 1) begin : g_bad_slice
    $error("mag_cmp_pipe: SLICE must be at least 1");
  end else if ((WIDTH % SLICE) != 0) begin : g_bad_width
    $error("mag_cmp_pipe: WIDTH must be a multiple of SLICE");
  end

  logic [WIDTH-1:0] a_cmp;
  logic [WIDTH-1:0] b_cmp;

`ifdef MAG_CMP_SIGNED_EN
  // Flipping the sign bit maps two's complement order onto unsigned order.
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);
  assign a_cmp = a ^ MSB_MASK;
  assign b_cmp = b ^ MSB_MASK;
`else
  assign a_cmp = a;
  assign b_cmp = b;
`endif

  logic   [NSTAGES-1:0] vld_q;
  logic   [NSTAGES-1:0] vld_d;
  logic   [NSTAGES-1:0] src_vld;
  logic   [NSTAGES:0]   load;
  flags_t [NSTAGES-1:0] flg_q;
  flags_t [NSTAGES-1:0] flg_d;
  flags_t [NSTAGES-1:0] sl_f;

  for (genvar gi = 0; gi < NSTAGES; gi++) begin : g_stage
    localparam int REM_IN  = WIDTH - gi * SLICE;
    localparam int REM_OUT = rem_bits(WIDTH, SLICE, gi);

    logic [REM_IN-1:0] cur_a;
    logic [REM_IN-1:0] cur_b;
    flags_t            in_f;

    if (gi == 0) begin : g_head
      assign cur_a = a_cmp;
      assign cur_b = b_cmp;
      assign in_f  = '0;
    end else begin : g_tail
      assign cur_a = g_stage[gi-1].g_rem.rem_a_q;
      assign cur_b = g_stage[gi-1].g_rem.rem_b_q;
      assign in_f  = flg_q[gi-1];
    end

    mag_cmp_slice #(
      .SLICE (SLICE)
    ) u_slice (
      .a_sl   (cur_a[REM_IN-1 -: SLICE]),
      .b_sl   (cur_b[REM_IN-1 -: SLICE]),
      .gt_in  (in_f.gt_d),
      .lt_in  (in_f.lt_d),
      .gt_out (sl_f[gi].gt_d),
      .lt_out (sl_f[gi].lt_d)
    );

    // Only the bits below this stage's slice travel onward; the last stage keeps none.
    if (REM_OUT > 0) begin : g_rem
      logic [REM_OUT-1:0] rem_a_q;
      logic [REM_OUT-1:0] rem_a_d;
      logic [REM_OUT-1:0] rem_b_q;
      logic [REM_OUT-1:0] rem_b_d;

      always_comb begin
        rem_a_d = rem_a_q;
        rem_b_d = rem_b_q;
        if (load[gi]) begin
          rem_a_d = cur_a[REM_OUT-1:0];
          rem_b_d = cur_b[REM_OUT-1:0];
        end
      end

      always_ff @(posedge clk) begin
        rem_a_q <= rem_a_d;
        rem_b_q <= rem_b_d;
      end
    end
  end

  // A stage loads when empty or when its successor drains it this cycle.
  always_comb begin
    load          = '0;
    vld_d         = vld_q;
    flg_d         = flg_q;
    src_vld       = NSTAGES'({vld_q, in_valid});
    load[NSTAGES] = out_ready;
    for (int i = NSTAGES - 1; i >= 0; i--) begin
      load[i] = ~vld_q[i] | load[i+1];
    end
    for (int i = 0; i < NSTAGES; i++) begin
      if (load[i]) begin
        vld_d[i] = src_vld[i];
        flg_d[i] = sl_f[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      flg_q <= '0;
    end else begin
      vld_q <= vld_d;
      flg_q <= flg_d;
    end
  end

  logic [FLAG_W-1:0] last_flags;
  logic [RES_W-1:0]  res;

  assign last_flags = flg_q[NSTAGES-1];

  always_comb begin
    res = '0;
    if (vld_q[NSTAGES-1]) begin
      case (last_flags)
        2'b10:   res = RES_GT;
        2'b01:   res = RES_LT;
        default: res = RES_EQ;
      endcase
    end
  end

  assign {gt, eq, lt} = res;
  assign out_valid    = vld_q[NSTAGES-1];
  assign in_ready     = load[0];

endmodule
